// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with registered read ports,
// optional write bypass, optional zero r0, and a clear sweep.
module reg_file_2r1w #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             le,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    sba,
  input  logic [AW-1:0]    sbb,
  input  logic             clr,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy,
  output logic             wr_drop
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd_a, rd_b;

  // state register and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next state: sweep starts on clr, ends after the last entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // outputs: busy and the effective write (sweep overrides external)
  always_comb begin
    busy = (state == CLEAR);
    we   = le;
    wa   = wsel;
    wd   = di;
    if (busy) begin
      we = 1'b1;
      wa = cnt;
      wd = '0;
    end
    if (ZERO_R0 != 0 && wa == '0)
      we = 1'b0;
  end

  // storage array
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // read data selection with optional forwarding of the current write
  always_comb begin
    rd_a = mem[sba];
    rd_b = mem[sbb];
    if (BYPASS != 0 && we && wa == sba)
      rd_a = wd;
    if (BYPASS != 0 && we && wa == sbb)
      rd_b = wd;
    if (ZERO_R0 != 0 && sba == '0)
      rd_a = '0;
    if (ZERO_R0 != 0 && sbb == '0)
      rd_b = '0;
  end

  // registered read ports and dropped-write flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a   <= '0;
      out_b   <= '0;
      wr_drop <= 1'b0;
    end else begin
      out_a   <= rd_a;
      out_b   <= rd_b;
      wr_drop <= busy && le;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: bypass and non-bypass 16x8
// instances share stimulus; a 32x32 zero-r0 instance runs separately.
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, le = 1'b0, clr = 1'b0;
  logic [3:0] wsel = '0, sba = '0, sbb = '0;
  logic [7:0] di = '0;
  logic [7:0] out_a0, out_b0, out_a1, out_b1;
  logic       busy0, drop0, busy1, drop1;

  logic        rst2 = 1'b0, le2 = 1'b0, clr2 = 1'b0;
  logic [4:0]  wsel2 = '0, sba2 = '0, sbb2 = '0;
  logic [31:0] di2 = '0;
  logic [31:0] out_a2, out_b2;
  logic        busy2, drop2;

  int checks = 0;
  int failures = 0;

  reg_file_2r1w #(.WIDTH(8), .DEPTH(16), .BYPASS(1), .ZERO_R0(0)) dut0 (
    .clk(clk), .rst(rst), .le(le), .wsel(wsel), .di(di),
    .sba(sba), .sbb(sbb), .clr(clr),
    .out_a(out_a0), .out_b(out_b0), .busy(busy0), .wr_drop(drop0)
  );

  reg_file_2r1w #(.WIDTH(8), .DEPTH(16), .BYPASS(0), .ZERO_R0(0)) dut1 (
    .clk(clk), .rst(rst), .le(le), .wsel(wsel), .di(di),
    .sba(sba), .sbb(sbb), .clr(clr),
    .out_a(out_a1), .out_b(out_b1), .busy(busy1), .wr_drop(drop1)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .BYPASS(1), .ZERO_R0(1)) dut2 (
    .clk(clk), .rst(rst2), .le(le2), .wsel(wsel2), .di(di2),
    .sba(sba2), .sbb(sbb2), .clr(clr2),
    .out_a(out_a2), .out_b(out_b2), .busy(busy2), .wr_drop(drop2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst2 = 1'b1;
    step();
    step();
    rst = 1'b0;
    rst2 = 1'b0;
    checks++;
    if ({out_a0, out_b0, busy0, drop0} !== 18'h0) begin
      failures++;
      $display("FAIL reset_dut0 got=%h/%h/%b/%b exp=0/0/0/0",
               out_a0, out_b0, busy0, drop0);
    end
    checks++;
    if ({out_a1, out_b1, busy1, drop1} !== 18'h0) begin
      failures++;
      $display("FAIL reset_dut1 got=%h/%h/%b/%b exp=0/0/0/0",
               out_a1, out_b1, busy1, drop1);
    end
    checks++;
    if ({out_a2, out_b2, busy2, drop2} !== 66'h0) begin
      failures++;
      $display("FAIL reset_dut2 got=%h/%h/%b/%b exp=0/0/0/0",
               out_a2, out_b2, busy2, drop2);
    end
  endtask

  task automatic test_readback();
    for (int i = 0; i < 16; i++) begin
      sba = 4'(i);
      sbb = 4'(15 - i);
      step();
      checks++;
      if (out_a0 !== 8'h00 || out_b0 !== 8'h00) begin
        failures++;
        $display("FAIL empty_read r%0d got=%h/%h exp=00/00",
                 i, out_a0, out_b0);
      end
    end
    le = 1'b1;
    wsel = 4'd3;
    di = 8'hA5;
    step();
    wsel = 4'd7;
    di = 8'h5A;
    step();
    le = 1'b0;
    sba = 4'd3;
    sbb = 4'd7;
    step();
    checks++;
    if (out_a0 !== 8'hA5 || out_b0 !== 8'h5A) begin
      failures++;
      $display("FAIL readback got=%h/%h exp=a5/5a", out_a0, out_b0);
    end
    checks++;
    if (out_a1 !== 8'hA5 || out_b1 !== 8'h5A) begin
      failures++;
      $display("FAIL readback_nobyp got=%h/%h exp=a5/5a", out_a1, out_b1);
    end
  endtask

  task automatic test_bypass();
    le = 1'b1;
    wsel = 4'd4;
    di = 8'h11;
    step();
    di = 8'h22;
    sba = 4'd4;
    sbb = 4'd4;
    step();
    le = 1'b0;
    checks++;
    if (out_a0 !== 8'h22 || out_b0 !== 8'h22) begin
      failures++;
      $display("FAIL bypass_on got=%h/%h exp=22/22", out_a0, out_b0);
    end
    checks++;
    if (out_a1 !== 8'h11 || out_b1 !== 8'h11) begin
      failures++;
      $display("FAIL bypass_off got=%h/%h exp=11/11", out_a1, out_b1);
    end
    step();
    checks++;
    if (out_a1 !== 8'h22) begin
      failures++;
      $display("FAIL bypass_off_next got=%h exp=22", out_a1);
    end
  endtask

  task automatic test_clear_sweep();
    int nbusy;
    logic [7:0] e0, e1;
    logic ed;
    for (int i = 0; i < 16; i++) begin
      le = 1'b1;
      wsel = 4'(i);
      di = 8'(8'h80 + i);
      step();
    end
    le = 1'b0;
    sba = 4'd5;
    sbb = 4'd10;
    clr = 1'b1;
    step();
    clr = 1'b0;
    nbusy = 0;
    for (int j = 0; j < 18; j++) begin
      e0 = (j < 6) ? 8'h85 : 8'h00;
      e1 = (j < 7) ? 8'h85 : 8'h00;
      ed = (j == 3 || j == 10);
      checks++;
      if (busy0 !== (j < 16) || busy1 !== (j < 16)) begin
        failures++;
        $display("FAIL sweep_busy j=%0d got=%b/%b exp=%b",
                 j, busy0, busy1, (j < 16));
      end
      checks++;
      if (out_a0 !== e0) begin
        failures++;
        $display("FAIL sweep_r5 j=%0d got=%h exp=%h", j, out_a0, e0);
      end
      checks++;
      if (out_a1 !== e1) begin
        failures++;
        $display("FAIL sweep_r5_nobyp j=%0d got=%h exp=%h", j, out_a1, e1);
      end
      checks++;
      if (drop0 !== ed || drop1 !== ed) begin
        failures++;
        $display("FAIL sweep_drop j=%0d got=%b/%b exp=%b",
                 j, drop0, drop1, ed);
      end
      if (busy0)
        nbusy++;
      le = (j == 2 || j == 9);
      wsel = 4'd10;
      di = 8'h33;
      step();
    end
    le = 1'b0;
    checks++;
    if (nbusy != 16) begin
      failures++;
      $display("FAIL sweep_len got=%0d exp=16", nbusy);
    end
    checks++;
    if (out_b0 !== 8'h00 || out_b1 !== 8'h00) begin
      failures++;
      $display("FAIL sweep_dropped_data got=%h/%h exp=00/00",
               out_b0, out_b1);
    end
  endtask

  task automatic test_clr_le_and_reset();
    logic [7:0] e0, e1;
    le = 1'b1;
    wsel = 4'd15;
    di = 8'hFF;
    clr = 1'b1;
    sba = 4'd15;
    sbb = 4'd15;
    step();
    le = 1'b0;
    clr = 1'b0;
    for (int j = 0; j < 18; j++) begin
      e0 = (j < 16) ? 8'hFF : 8'h00;
      e1 = (j == 0 || j >= 17) ? 8'h00 : 8'hFF;
      checks++;
      if (out_a0 !== e0 || out_b0 !== e0) begin
        failures++;
        $display("FAIL clr_le_r15 j=%0d got=%h/%h exp=%h",
                 j, out_a0, out_b0, e0);
      end
      checks++;
      if (out_a1 !== e1) begin
        failures++;
        $display("FAIL clr_le_r15_nobyp j=%0d got=%h exp=%h",
                 j, out_a1, e1);
      end
      step();
    end
    le = 1'b1;
    wsel = 4'd2;
    di = 8'h77;
    step();
    wsel = 4'd12;
    di = 8'h99;
    step();
    le = 1'b0;
    sba = 4'd12;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int j = 0; j < 8; j++)
      step();
    checks++;
    if (busy0 !== 1'b1 || out_a0 !== 8'h99) begin
      failures++;
      $display("FAIL mid_sweep got=%b/%h exp=1/99", busy0, out_a0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || out_a0 !== 8'h00) begin
      failures++;
      $display("FAIL abort_busy got=%b/%b/%h exp=0/0/00",
               busy0, busy1, out_a0);
    end
    for (int i = 0; i < 16; i++) begin
      sba = 4'(i);
      sbb = 4'(i);
      step();
      checks++;
      if ({out_a0, out_b0, out_a1, out_b1} !== 32'h0) begin
        failures++;
        $display("FAIL abort_regs r%0d got=%h/%h/%h/%h exp=0",
                 i, out_a0, out_b0, out_a1, out_b1);
      end
    end
  endtask

  task automatic test_zero_r0_wide();
    int nbusy;
    le2 = 1'b1;
    wsel2 = 5'd0;
    di2 = 32'hDEADBEEF;
    sba2 = 5'd0;
    sbb2 = 5'd0;
    step();
    le2 = 1'b0;
    checks++;
    if (out_a2 !== 32'h0 || out_b2 !== 32'h0 || drop2 !== 1'b0) begin
      failures++;
      $display("FAIL r0_bypass got=%h/%h/%b exp=0/0/0",
               out_a2, out_b2, drop2);
    end
    step();
    checks++;
    if (out_a2 !== 32'h0 || drop2 !== 1'b0) begin
      failures++;
      $display("FAIL r0_read got=%h/%b exp=0/0", out_a2, drop2);
    end
    le2 = 1'b1;
    wsel2 = 5'd31;
    step();
    le2 = 1'b0;
    sba2 = 5'd31;
    sbb2 = 5'd31;
    step();
    checks++;
    if (out_a2 !== 32'hDEADBEEF || out_b2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL r31_read got=%h/%h exp=deadbeef",
               out_a2, out_b2);
    end
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    nbusy = 0;
    for (int j = 0; j < 40; j++) begin
      if (busy2)
        nbusy++;
      step();
    end
    checks++;
    if (nbusy != 32) begin
      failures++;
      $display("FAIL wide_sweep_len got=%0d exp=32", nbusy);
    end
    checks++;
    if (out_a2 !== 32'h0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL wide_sweep_r31 got=%h/%b exp=0/0", out_a2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_bypass();
    test_clear_sweep();
    test_clr_le_and_reset();
    test_zero_r0_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file for the single-clock processor datapath: one write port, two independently addressed read ports (A and B) with registered outputs, optional read-after-write bypass, optional hard-wired-zero register 0, and a clear sequencer that zeroes the whole array one entry per cycle on command. It sits between the write-back bus and the ALU operand inputs. It generalises the fixed 16 x 8 file with its load enable and A/B bus selects.

## Interface

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 16, number of registers; must be a power of 2, at least 2.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a read port addressing the written register; 0 = read returns the pre-write value.
- ZERO_R0, 0, 1 = register 0 is read-only and always reads 0.
- AW, local, equal to $clog2(DEPTH).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- le  in  1  write (load) enable.
- wsel  in  AW  write register index.
- di  in  WIDTH  write data.
- sba  in  AW  read port A register index.
- sbb  in  AW  read port B register index.
- clr  in  1  start a clear sweep; single-cycle request.
- out_a  out  WIDTH  registered read data, port A.
- out_b  out  WIDTH  registered read data, port B.
- busy  out  1  high while the clear sweep runs.
- wr_drop  out  1  registered one-cycle pulse; a write was discarded because busy was high.

## Operation

- State machine: IDLE and CLEAR; a sweep counter cnt of AW bits.
- IDLE:
  - If le=1, then reg[wsel] <= di on the edge.
  - If clr=1, then go to CLEAR with cnt <= 0. The write and clr are both honoured if they occur in the same cycle.
- CLEAR, on each edge:
  - reg[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == DEPTH-1, return to IDLE.
  - External writes are ignored. le=1 produces wr_drop=1 on the next cycle.
  - clr is ignored.
- Effective write in a cycle:
  - In CLEAR: index cnt, data 0, always enabled.
  - In IDLE: index wsel, data di, enabled by le.
- Reads, for each port independently:
  - out_x <= reg[sbx] as it stands before the edge.
  - If BYPASS=1 and an effective write targets sbx in the same cycle, out_x <= the write data instead.
- ZERO_R0=1:
  - Writes to index 0 are discarded silently; wr_drop is not asserted.
  - Reads of index 0 return 0, including under bypass.
- Both ports may address the same register; they return identical data.

## Timing

- Read latency is 1 cycle: sba is presented in cycle k and out_a is valid after edge k.
- Write latency is 1 cycle: a register written at edge k is visible through a non-bypassed read issued in cycle k+1.
- Sweep length:
  - clr sampled at edge k; busy=1 from after edge k to after edge k+DEPTH.
  - Register i is zeroed at edge k+1+i.
  - busy is high for exactly DEPTH cycles.
- A new clr is accepted in the first cycle busy=0.
- rst=1 at an edge, regardless of state:
  - all registers <= 0;
  - out_a, out_b <= 0;
  - busy <= 0, wr_drop <= 0;
  - state <= IDLE, cnt <= 0.
- rst has priority over le and clr in the same cycle. rst during a sweep aborts it.
- Outputs after reset: out_a=0, out_b=0, busy=0, wr_drop=0.

## Test plan

- **Reset and write/readback:** defaults (WIDTH=8, DEPTH=16). Apply rst, then write 0xA5 to r3 and 0x5A to r7 in consecutive cycles, then read sba=3, sbb=7 -> out_a=0xA5 and out_b=0x5A one cycle later. Before the writes, every read returns 0x00.
- **Bypass on/off:** r4=0x11, then le=1, wsel=4, di=0x22 with sba=4 in the same cycle.
  - BYPASS=1 -> out_a=0x22.
  - BYPASS=0 -> out_a=0x11, then 0x22 on the next read.
- **Clear sweep:** fill r0..r15 with 0x80+i, then pulse clr.
  - busy is high for exactly 16 cycles.
  - Reading sba=5 each cycle shows 0x85 until the edge k+6, then 0x00.
  - Writes during the sweep give one wr_drop pulse each, and their data never appears.
- **Simultaneous clr+le and reset mid-sweep:** le=1, wsel=15, di=0xFF with clr=1 -> r15 reads 0xFF during the sweep, then 0x00 after the final sweep edge. Asserting rst at sweep cycle 8 -> busy=0 on the next cycle and all registers read 0.
- **ZERO_R0=1 and wide config:** WIDTH=32, DEPTH=32. Write 0xDEADBEEF to r0 -> reads 0, wr_drop=0. Write the same value to r31 -> reads 0xDEADBEEF on both ports. The sweep lasts 32 cycles.
